// File: rtl/mc_main_control_if.sv
// Control bus between the multicycle MIPS main controller and its datapath.
// Master is the controller; slave is the datapath side.
interface mc_main_control_if;
    logic [5:0] Opcode;
    logic       mem_ready;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       RegDst;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSource;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
        input  Opcode, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, illegal_op, state
    );

    modport slave (
        output Opcode, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, illegal_op, state
    );
endinterface

// File: rtl/mc_main_control.sv
// Multicycle MIPS main control FSM: fetch/decode/execute/memory/writeback sequencing
// with mem_ready stalls; all datapath controls decode combinationally from the state.
module mc_main_control (
    input  logic               clk,
    input  logic               rst_n,
    mc_main_control_if.master  bus
);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_ADDIEX = 4'd11,
        S_ADDIWB = 4'd12
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic       w_pcWrite;
    logic       w_pcWriteCond;
    logic       w_iorD;
    logic       w_memRead;
    logic       w_memWrite;
    logic       w_irWrite;
    logic       w_memtoReg;
    logic       w_regDst;
    logic       w_regWrite;
    logic       w_aluSrcA;
    logic [1:0] w_aluSrcB;
    logic [1:0] w_aluOp;
    logic [1:0] w_pcSource;
    logic       w_illegalOp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Unused encodings 13-15 fall through to the defaults: outputs 0, back to IDLE.
    always_comb begin
        w_next        = S_IDLE;
        w_pcWrite     = 1'b0;
        w_pcWriteCond = 1'b0;
        w_iorD        = 1'b0;
        w_memRead     = 1'b0;
        w_memWrite    = 1'b0;
        w_irWrite     = 1'b0;
        w_memtoReg    = 1'b0;
        w_regDst      = 1'b0;
        w_regWrite    = 1'b0;
        w_aluSrcA     = 1'b0;
        w_aluSrcB     = 2'b00;
        w_aluOp       = 2'b00;
        w_pcSource    = 2'b00;
        w_illegalOp   = 1'b0;
        case (r_state)
            S_IDLE: w_next = S_FETCH;
            S_FETCH: begin
                w_memRead = 1'b1;
                w_aluSrcB = 2'b01;
                w_irWrite = bus.mem_ready;
                w_pcWrite = bus.mem_ready;
                w_next    = bus.mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                w_aluSrcB = 2'b11;
                case (bus.Opcode)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXEC;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_J:         w_next = S_JUMP;
                    OP_ADDI:      w_next = S_ADDIEX;
                    default: begin
                        w_illegalOp = 1'b1;
                        w_next      = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                w_aluSrcA = 1'b1;
                w_aluSrcB = 2'b10;
                w_next    = (bus.Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                w_memRead = 1'b1;
                w_iorD    = 1'b1;
                w_next    = bus.mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                w_regWrite = 1'b1;
                w_memtoReg = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEMWR: begin
                w_memWrite = 1'b1;
                w_iorD     = 1'b1;
                w_next     = bus.mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                w_aluSrcA = 1'b1;
                w_aluOp   = 2'b10;
                w_next    = S_ALUWB;
            end
            S_ALUWB: begin
                w_regWrite = 1'b1;
                w_regDst   = 1'b1;
                w_next     = S_FETCH;
            end
            S_BRANCH: begin
                w_aluSrcA     = 1'b1;
                w_aluOp       = 2'b01;
                w_pcWriteCond = 1'b1;
                w_pcSource    = 2'b01;
                w_next        = S_FETCH;
            end
            S_JUMP: begin
                w_pcWrite  = 1'b1;
                w_pcSource = 2'b10;
                w_next     = S_FETCH;
            end
            S_ADDIEX: begin
                w_aluSrcA = 1'b1;
                w_aluSrcB = 2'b10;
                w_next    = S_ADDIWB;
            end
            S_ADDIWB: begin
                w_regWrite = 1'b1;
                w_next     = S_FETCH;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign bus.PCWrite     = w_pcWrite;
    assign bus.PCWriteCond = w_pcWriteCond;
    assign bus.IorD        = w_iorD;
    assign bus.MemRead     = w_memRead;
    assign bus.MemWrite    = w_memWrite;
    assign bus.IRWrite     = w_irWrite;
    assign bus.MemtoReg    = w_memtoReg;
    assign bus.RegDst      = w_regDst;
    assign bus.RegWrite    = w_regWrite;
    assign bus.ALUSrcA     = w_aluSrcA;
    assign bus.ALUSrcB     = w_aluSrcB;
    assign bus.ALUOp       = w_aluOp;
    assign bus.PCSource    = w_pcSource;
    assign bus.illegal_op  = w_illegalOp;
    assign bus.state       = r_state;
endmodule

// File: tb/tb_mc_main_control.sv
// Directed bench for mc_main_control: walks every instruction class, memory stalls,
// illegal opcodes and asynchronous reset, comparing against hand-computed vectors.
module tb_mc_main_control;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mc_main_control_if bus ();

    mc_main_control dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    // Output vector: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg RegDst
    // RegWrite ALUSrcA ALUSrcB[2] ALUOp[2] PCSource[2] illegal_op
    localparam logic [16:0] O_ZERO     = 17'b0;
    localparam logic [16:0] O_FETCH_R  = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
    localparam logic [16:0] O_FETCH_W  = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
    localparam logic [16:0] O_DECODE   = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
    localparam logic [16:0] O_ILLEGAL  = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_1;
    localparam logic [16:0] O_MEMADR   = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [16:0] O_MEMRD    = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] O_MEMWB    = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
    localparam logic [16:0] O_MEMWR    = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] O_EXEC     = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
    localparam logic [16:0] O_ALUWB    = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
    localparam logic [16:0] O_BRANCH   = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
    localparam logic [16:0] O_JUMP     = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;
    localparam logic [16:0] O_ADDIWB   = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;

    function automatic logic [16:0] outVec();
        return {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA,
                bus.ALUSrcB, bus.ALUOp, bus.PCSource, bus.illegal_op};
    endfunction

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.Opcode    = OP_R;
        bus.mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (bus.state !== 4'd0) begin
            errors++;
            $display("[TB] FAIL reset_state: got %0d expected 0", bus.state);
        end
        checks++;
        if (outVec() !== O_ZERO) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %b expected %b", outVec(), O_ZERO);
        end
    endtask

    task automatic test_rtype();
        logic [3:0]  st[$];
        logic [16:0] ex[$];
        logic        rd[$];
        logic [5:0]  op[$];
        st = '{4'd0, 4'd1, 4'd2, 4'd7, 4'd8, 4'd1};
        ex = '{O_ZERO, O_FETCH_R, O_DECODE, O_EXEC, O_ALUWB, O_FETCH_R};
        rd = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        op = '{OP_R, OP_R, OP_R, OP_R, OP_R, OP_R};
        rst_n = 1'b1;
        for (int i = 0; i < st.size(); i++) begin
            if (i > 0) @(negedge clk);
            bus.Opcode = op[i]; bus.mem_ready = rd[i];
            #1;
            checks++;
            if (bus.state !== st[i]) begin
                errors++;
                $display("[TB] FAIL rtype_state step %0d: got %0d expected %0d", i, bus.state, st[i]);
            end
            checks++;
            if (outVec() !== ex[i]) begin
                errors++;
                $display("[TB] FAIL rtype_out step %0d: got %b expected %b", i, outVec(), ex[i]);
            end
        end
    endtask

    task automatic test_lw_stall();
        logic [3:0]  st[$];
        logic [16:0] ex[$];
        logic        rd[$];
        st = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 4'd4, 4'd4, 4'd5, 4'd1};
        ex = '{O_FETCH_R, O_DECODE, O_MEMADR, O_MEMRD, O_MEMRD, O_MEMRD, O_MEMRD, O_MEMWB, O_FETCH_R};
        rd = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < st.size(); i++) begin
            if (i > 0) @(negedge clk);
            bus.Opcode = OP_LW; bus.mem_ready = rd[i];
            #1;
            checks++;
            if (bus.state !== st[i]) begin
                errors++;
                $display("[TB] FAIL lw_state step %0d: got %0d expected %0d", i, bus.state, st[i]);
            end
            checks++;
            if (outVec() !== ex[i]) begin
                errors++;
                $display("[TB] FAIL lw_out step %0d: got %b expected %b", i, outVec(), ex[i]);
            end
        end
    endtask

    task automatic test_sw();
        logic [3:0]  st[$];
        logic [16:0] ex[$];
        st = '{4'd1, 4'd2, 4'd3, 4'd6, 4'd1};
        ex = '{O_FETCH_R, O_DECODE, O_MEMADR, O_MEMWR, O_FETCH_R};
        for (int i = 0; i < st.size(); i++) begin
            if (i > 0) @(negedge clk);
            bus.Opcode = OP_SW; bus.mem_ready = 1'b1;
            #1;
            checks++;
            if (bus.state !== st[i]) begin
                errors++;
                $display("[TB] FAIL sw_state step %0d: got %0d expected %0d", i, bus.state, st[i]);
            end
            checks++;
            if (outVec() !== ex[i]) begin
                errors++;
                $display("[TB] FAIL sw_out step %0d: got %b expected %b", i, outVec(), ex[i]);
            end
        end
    endtask

    task automatic test_addi_fetch_stall();
        logic [3:0]  st[$];
        logic [16:0] ex[$];
        logic        rd[$];
        st = '{4'd1, 4'd1, 4'd2, 4'd11, 4'd12, 4'd1};
        ex = '{O_FETCH_W, O_FETCH_R, O_DECODE, O_MEMADR, O_ADDIWB, O_FETCH_R};
        rd = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < st.size(); i++) begin
            if (i > 0) @(negedge clk);
            bus.Opcode = OP_ADDI; bus.mem_ready = rd[i];
            #1;
            checks++;
            if (bus.state !== st[i]) begin
                errors++;
                $display("[TB] FAIL addi_state step %0d: got %0d expected %0d", i, bus.state, st[i]);
            end
            checks++;
            if (outVec() !== ex[i]) begin
                errors++;
                $display("[TB] FAIL addi_out step %0d: got %b expected %b", i, outVec(), ex[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  st[$];
        logic [16:0] ex[$];
        logic [5:0]  op[$];
        st = '{4'd1, 4'd2, 4'd9, 4'd1, 4'd2, 4'd10, 4'd1, 4'd2, 4'd1};
        ex = '{O_FETCH_R, O_DECODE, O_BRANCH, O_FETCH_R, O_DECODE, O_JUMP, O_FETCH_R, O_ILLEGAL, O_FETCH_R};
        op = '{OP_BEQ, OP_BEQ, OP_BEQ, OP_J, OP_J, OP_J, OP_BAD, OP_BAD, OP_BAD};
        for (int i = 0; i < st.size(); i++) begin
            if (i > 0) @(negedge clk);
            bus.Opcode = op[i]; bus.mem_ready = 1'b1;
            #1;
            checks++;
            if (bus.state !== st[i]) begin
                errors++;
                $display("[TB] FAIL b2b_state step %0d: got %0d expected %0d", i, bus.state, st[i]);
            end
            checks++;
            if (outVec() !== ex[i]) begin
                errors++;
                $display("[TB] FAIL b2b_out step %0d: got %b expected %b", i, outVec(), ex[i]);
            end
        end
    endtask

    task automatic test_reset_mid_memwr();
        logic [3:0]  st[$];
        logic [16:0] ex[$];
        logic        rd[$];
        st = '{4'd1, 4'd2, 4'd3, 4'd6, 4'd6};
        ex = '{O_FETCH_R, O_DECODE, O_MEMADR, O_MEMWR, O_MEMWR};
        rd = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < st.size(); i++) begin
            if (i > 0) @(negedge clk);
            bus.Opcode = OP_SW; bus.mem_ready = rd[i];
            #1;
            checks++;
            if (bus.state !== st[i]) begin
                errors++;
                $display("[TB] FAIL midrst_state step %0d: got %0d expected %0d", i, bus.state, st[i]);
            end
            checks++;
            if (outVec() !== ex[i]) begin
                errors++;
                $display("[TB] FAIL midrst_out step %0d: got %b expected %b", i, outVec(), ex[i]);
            end
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.MemWrite !== 1'b0 || bus.state !== 4'd0) begin
            errors++;
            $display("[TB] FAIL midrst_async: got MemWrite=%b state=%0d expected MemWrite=0 state=0",
                     bus.MemWrite, bus.state);
        end
        checks++;
        if (outVec() !== O_ZERO) begin
            errors++;
            $display("[TB] FAIL midrst_outputs: got %b expected %b", outVec(), O_ZERO);
        end
        @(negedge clk);
        rst_n      = 1'b1;
        bus.Opcode = OP_R;
        bus.mem_ready = 1'b1;
        #1;
        checks++;
        if (bus.state !== 4'd0) begin
            errors++;
            $display("[TB] FAIL midrst_idle: got %0d expected 0", bus.state);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.state !== 4'd1 || outVec() !== O_FETCH_R) begin
            errors++;
            $display("[TB] FAIL midrst_resume: got state=%0d out=%b expected state=1 out=%b",
                     bus.state, outVec(), O_FETCH_R);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_rtype();
        test_lw_stall();
        test_sw();
        test_addi_fetch_stall();
        test_back_to_back();
        test_reset_mid_memwr();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
